// File: rtl/interrupt_sequencer_if.sv
// 16-bit stack port shared between the interrupt sequencer and the data memory.
// One request per cycle; Mem_Ready acknowledges a push or qualifies Pop_Data.
interface interrupt_sequencer_if;
  logic        Stack_Req;
  logic        Stack_Write;
  logic [15:0] Stack_Data;
  logic        Mem_Ready;
  logic [15:0] Pop_Data;

  modport master (
    output Stack_Req,
    output Stack_Write,
    output Stack_Data,
    input  Mem_Ready,
    input  Pop_Data
  );

  modport slave (
    input  Stack_Req,
    input  Stack_Write,
    input  Stack_Data,
    output Mem_Ready,
    output Pop_Data
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return controller: pushes PC and flags to the stack,
// redirects fetch to the vector, and later pops them back while freezing the front end.
module interrupt_sequencer #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0010
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   INT,
  input  logic                   RTI_Start,
  input  logic [31:0]            Resume_PC,
  input  logic [2:0]             Flags,
  interrupt_sequencer_if.master  stack,
  output logic                   Stall,
  output logic                   Flush,
  output logic                   PC_Load,
  output logic [31:0]            PC_Value,
  output logic                   Flags_Load,
  output logic [2:0]             Flags_Restore,
  output logic                   Int_Enable
);

  typedef enum logic [3:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    PUSH_FLG,
    VECTOR,
    POP_FLG,
    POP_LO,
    POP_HI,
    RESUME
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        pending;
  logic        entry_start;
  logic [31:0] saved_pc;
  logic [2:0]  saved_flags;
  logic [15:0] ret_lo;
  logic [15:0] ret_hi;
  logic [2:0]  restore_flags;

  assign entry_start = (state == IDLE) && (state_n == PUSH_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A request that arrives mid-sequence (or while masked) waits here until IDLE can take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (entry_start) begin
      pending <= 1'b0;
    end else if (INT) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saved_pc      <= '0;
      saved_flags   <= '0;
      ret_lo        <= '0;
      ret_hi        <= '0;
      restore_flags <= '0;
      Int_Enable    <= 1'b1;
    end else begin
      if (entry_start) begin
        saved_pc    <= Resume_PC;
        saved_flags <= Flags;
      end
      if (stack.Mem_Ready) begin
        case (state)
          POP_FLG: restore_flags <= stack.Pop_Data[2:0];
          POP_LO:  ret_lo        <= stack.Pop_Data;
          POP_HI:  ret_hi        <= stack.Pop_Data;
          default: ;
        endcase
      end
      if (state == VECTOR) begin
        Int_Enable <= 1'b0;
      end else if (state == RESUME) begin
        Int_Enable <= 1'b1;
      end
    end
  end

  // RTI wins over any interrupt in IDLE; every stack state waits on Mem_Ready.
  always_comb begin
    state_n           = state;
    Stall             = 1'b1;
    Flush             = 1'b0;
    PC_Load           = 1'b0;
    PC_Value          = '0;
    Flags_Load        = 1'b0;
    Flags_Restore     = '0;
    stack.Stack_Req   = 1'b0;
    stack.Stack_Write = 1'b0;
    stack.Stack_Data  = '0;
    case (state)
      IDLE: begin
        Stall = 1'b0;
        if (RTI_Start) begin
          state_n = POP_FLG;
        end else if ((pending || INT) && Int_Enable) begin
          state_n = PUSH_HI;
        end
      end
      PUSH_HI: begin
        stack.Stack_Req   = 1'b1;
        stack.Stack_Write = 1'b1;
        stack.Stack_Data  = saved_pc[31:16];
        if (stack.Mem_Ready) state_n = PUSH_LO;
      end
      PUSH_LO: begin
        stack.Stack_Req   = 1'b1;
        stack.Stack_Write = 1'b1;
        stack.Stack_Data  = saved_pc[15:0];
        if (stack.Mem_Ready) state_n = PUSH_FLG;
      end
      PUSH_FLG: begin
        stack.Stack_Req   = 1'b1;
        stack.Stack_Write = 1'b1;
        stack.Stack_Data  = {13'b0, saved_flags};
        if (stack.Mem_Ready) state_n = VECTOR;
      end
      VECTOR: begin
        PC_Load  = 1'b1;
        PC_Value = INT_VECTOR;
        Flush    = 1'b1;
        state_n  = IDLE;
      end
      POP_FLG: begin
        stack.Stack_Req = 1'b1;
        if (stack.Mem_Ready) state_n = POP_LO;
      end
      POP_LO: begin
        stack.Stack_Req = 1'b1;
        if (stack.Mem_Ready) state_n = POP_HI;
      end
      POP_HI: begin
        stack.Stack_Req = 1'b1;
        if (stack.Mem_Ready) state_n = RESUME;
      end
      RESUME: begin
        PC_Load       = 1'b1;
        PC_Value      = {ret_hi, ret_lo};
        Flags_Load    = 1'b1;
        Flags_Restore = restore_flags;
        Flush         = 1'b1;
        state_n       = IDLE;
      end
      default: begin
        Stall   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Multi-cycle controller beside the execution stage; sequences hardware interrupt entry and RTI return over the 16-bit stack port.
- Entry: pushes the 32-bit resume PC as two 16-bit words, then the NF|OF|ZF flags, then redirects fetch to the interrupt vector.
- RTI: pops the flags and PC back in reverse order.
- Freezes the front pipeline (IF/ID, ID/EX) while a sequence runs.

Parameters:
INT_VECTOR, 32'h0000_0010, PC loaded on interrupt entry.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
INT  input  1  interrupt request; a one-cycle pulse is sufficient and is latched
RTI_Start  input  1  RTI decoded and valid in EX this cycle
Resume_PC  input  32  PC to return to after the interrupt, sampled at sequence start
Flags  input  3  current NF|OF|ZF, sampled at sequence start
Mem_Ready  input  1  stack port accepted this cycle's request (push written / pop data valid)
Pop_Data  input  16  stack read data, valid when Stack_Req & ~Stack_Write & Mem_Ready
Stall  output  1  freeze PC, IF/ID and ID/EX
Flush  output  1  bubble ID/EX on redirect
Stack_Req  output  1  stack access request
Stack_Write  output  1  1 = push, 0 = pop
Stack_Data  output  16  push data
PC_Load  output  1  load PC_Value into PC this cycle
PC_Value  output  32  redirect target
Flags_Load  output  1  overwrite flags register with Flags_Restore
Flags_Restore  output  3  restored NF|OF|ZF
Int_Enable  output  1  interrupts accepted (cleared on entry, set on RTI completion)

Behaviour:
- Reset (async, any state):
  - state = IDLE; pending = 0; Int_Enable = 1; saved PC/flags = 0.
  - All request and strobe outputs = 0; Stack_Data = 0; PC_Value = 0; Flags_Restore = 0.
- pending: set on any cycle with INT = 1; cleared on the edge that leaves IDLE for PUSH_HI. An INT arriving during a sequence stays pending.
- States: IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, VECTOR, POP_FLG, POP_LO, POP_HI, RESUME.
- IDLE:
  - If RTI_Start = 1, go to POP_FLG. RTI has priority over a same-cycle or pending interrupt.
  - Else if (pending | INT) & Int_Enable, latch Resume_PC and Flags, then go to PUSH_HI.
- PUSH_HI / PUSH_LO / PUSH_FLG:
  - Stack_Req = 1, Stack_Write = 1.
  - Stack_Data = saved PC[31:16] / saved PC[15:0] / {13'b0, saved flags}.
  - Advance on Mem_Ready = 1; otherwise hold with outputs stable.
- VECTOR (exactly 1 cycle):
  - PC_Load = 1, PC_Value = INT_VECTOR, Flush = 1, Int_Enable <= 0.
  - Go to IDLE.
- POP_FLG / POP_LO / POP_HI:
  - Stack_Req = 1, Stack_Write = 0.
  - On Mem_Ready, capture Pop_Data[2:0] into restore flags, Pop_Data into ret[15:0], or Pop_Data into ret[31:16] respectively, then advance.
- RESUME (exactly 1 cycle):
  - PC_Load = 1, PC_Value = {ret_hi, ret_lo}.
  - Flags_Load = 1, Flags_Restore = restored flags.
  - Flush = 1, Int_Enable <= 1.
  - Go to IDLE.
- Stall = 1 in every state except IDLE (Moore; the sequence-start cycle itself is not stalled).
- Latency, zero wait states:
  - Entry is 4 cycles after the trigger edge (3 pushes + VECTOR).
  - RTI is 4 cycles (3 pops + RESUME).
  - Each Mem_Ready = 0 cycle adds one cycle.
- A pending interrupt after RESUME is taken on the next IDLE cycle. Int_Enable is already 1 there, so back-to-back sequences have exactly 1 IDLE cycle between them.
- Outputs decode from state and registers only. Stack_Data, PC_Value and Flags_Restore are 0 in states where they are unused.
- RTI_Start outside IDLE is ignored (the front end is stalled, so it cannot legally occur).

Test Plan:
- Reset, then INT pulse with Resume_PC = 32'h0001_2345, Flags = 3'b101, Mem_Ready = 1 -> pushes 16'h0001, 16'h2345, 16'h0005 on consecutive cycles; then PC_Load with 32'h0000_0010 and Flush; Stall high for 4 cycles; Int_Enable = 0 afterwards.
- RTI_Start with Mem_Ready = 1 and Pop_Data = 16'h0005, 16'h2345, 16'h0001 -> RESUME drives PC_Value = 32'h0001_2345, Flags_Restore = 3'b101, Flags_Load = 1; Int_Enable returns to 1.
- Mem_Ready held 0 for 3 cycles in PUSH_LO -> Stack_Data held at the low PC word; total entry takes 7 cycles; no state skip.
- INT and RTI_Start in the same IDLE cycle (Int_Enable = 1) -> RTI sequence runs first; pending stays 1; interrupt entry starts on the IDLE cycle right after RESUME.
- INT pulse while Int_Enable = 0 (inside a handler) -> no entry; entry begins the cycle after RTI's RESUME returns to IDLE.
- rst asserted mid-POP_LO -> outputs go to 0 immediately (async); state IDLE, pending 0, Int_Enable 1; the next INT starts a clean entry.
